// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and a two's-complement conditional-negate helper.
package muldiv_pkg;

    // Operation codes as presented by the decoder on op[1:0]
    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    // Top-level FSM states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Widest operand the helper handles; callers zero-extend into it and
    // truncate the result back to their own width, which keeps the
    // two's-complement result exact for any WIDTH up to this value.
    localparam int MD_MAXW = 64;
    typedef logic [MD_MAXW-1:0] md_word_t;

    // Conditional two's-complement negate: magnitude of a negative value,
    // or re-applying a sign to a magnitude.
    function automatic md_word_t md_cneg(input md_word_t x, input logic neg);
        return neg ? (~x + md_word_t'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned WIDTH-bit operands.
// One quotient bit per cycle, MSB first; results are stable once done pulses
// and until the next start.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_quot;   // shifts dividend out, quotient bits in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    // Partial remainder shifted left with the next dividend bit; one extra
    // bit so the trial subtraction's sign shows whether the divisor fits.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // Load on start, then one restoring step per cycle until the counter expires
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_quot <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
                r_cnt  <= CW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide execution unit. Signed/unsigned multiply through a
// MUL_LAT-deep product pipeline (the HI/LO registers are its last stage),
// and signed/unsigned divide built on div_core with sign fix-up afterwards.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [2:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;
    logic [MCW-1:0]   r_mcnt;

    logic             w_accept;
    logic             w_core_start;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_core_busy;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_q;
    logic [WIDTH-1:0] w_core_r;
    logic             w_signed;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [2*WIDTH-1:0] w_ea;
    logic [2*WIDTH-1:0] w_eb;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_out;

    // A request is taken in IDLE and in DONE (back-to-back); flush drops it
    assign w_accept = start & ~flush & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // The divider is launched straight from the input operands in the
    // accept cycle so its WIDTH steps overlap the first DIV cycle; a zero
    // divisor never starts it.
    assign w_core_start = w_accept & op[1] & (b != '0);
    assign w_mag_a = WIDTH'(md_cneg(MD_MAXW'(a), ~op[0] & a[WIDTH-1]));
    assign w_mag_b = WIDTH'(md_cneg(MD_MAXW'(b), ~op[0] & b[WIDTH-1]));

    div_core #(.WIDTH(WIDTH)) u_div (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_start    (w_core_start),
        .i_flush    (flush),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_busy     (w_core_busy),
        .o_done     (w_core_done),
        .o_quot     (w_core_q),
        .o_rem      (w_core_r)
    );

    // Sign restoration: quotient negative when operand signs differ,
    // remainder follows the dividend.
    assign w_signed = ~r_op[0];
    assign w_q_fix  = WIDTH'(md_cneg(MD_MAXW'(w_core_q), w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1])));
    assign w_r_fix  = WIDTH'(md_cneg(MD_MAXW'(w_core_r), w_signed & r_a[WIDTH-1]));

    // Full-width product of the latched operands, sign- or zero-extended
    assign w_ea   = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
    assign w_eb   = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ea * w_eb;

    generate
        if (MUL_LAT > 1) begin : g_mpipe
            logic [MUL_LAT-2:0][2*WIDTH-1:0] r_mpipe;

            // Product pipeline, advanced only while a multiply is in flight
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_mpipe <= '0;
                end else if (r_state == ST_MUL) begin
                    r_mpipe[0] <= w_prod;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        r_mpipe[i] <= r_mpipe[i-1];
                    end
                end
            end

            assign w_mul_out = r_mpipe[MUL_LAT-2];
        end else begin : g_mcomb
            assign w_mul_out = w_prod;
        end
    endgenerate

    // Control FSM; also owns operand latches and the HI/LO/flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
            r_mcnt  <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_mcnt  <= MCW'(MUL_LAT - 1);
                        r_state <= op[1] ? ST_DIV : ST_MUL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (r_mcnt == '0) begin
                        r_hi    <= w_mul_out[2*WIDTH-1:WIDTH];
                        r_lo    <= w_mul_out[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_mcnt <= r_mcnt - MCW'(1);
                    end
                end
                ST_DIV: begin
                    if (r_b == '0) begin
                        r_hi    <= r_a;
                        r_lo    <= '1;
                        r_dbz   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_core_done) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_r_fix;
                    r_lo    <= w_q_fix;
                    r_dbz   <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == ST_MUL) | (r_state == ST_DIV) | (r_state == ST_FIX) | w_core_busy;
    assign done        = (r_state == ST_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the reference result
// and expected done cycle for every accepted request; the monitor pops and
// compares on every done pulse and flags spurious or missing completions.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int ML = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    op    = 2'b00;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          dbz;

    muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic        last_dbz = 1'b0;

    // Reference: plain integer arithmetic on the architectural rules
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int at);
        exp_t        e;
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        e.op = o; e.a = x; e.b = y; e.dbz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; e.at = at + ML; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; e.at = at + ML; end
            default: begin
                if (y == 0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.at = at + 1;
                end else begin
                    if (o == 2'b10) begin sq = sx / sy; sr = sx % sy; end
                    else begin sq = longint'(x / y); sr = longint'(x % y); end
                    e.lo = sq[31:0]; e.hi = sr[31:0]; e.at = at + W + 2;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (done) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_done cyc=%0d hi=%h lo=%h", cyc, hi, lo);
                end else begin
                    e = sbq.pop_front();
                    if (hi !== e.hi || lo !== e.lo || dbz !== e.dbz || cyc != e.at) begin
                        n_err++;
                        $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b cyc=%0d want hi=%h lo=%h dbz=%b cyc=%0d",
                                 e.op, e.a, e.b, hi, lo, dbz, cyc, e.hi, e.lo, e.dbz, e.at);
                    end
                    last_hi = e.hi; last_lo = e.lo; last_dbz = e.dbz;
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
                e = sbq.pop_front();
                n_vec++; n_err++;
                $display("FAIL missing_done op=%0d a=%h b=%h due cyc=%0d now %0d", e.op, e.a, e.b, e.at, cyc);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; waits for idle, presents one request for one cycle
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        int g = 0;
        while (busy && g < 200) begin @(negedge clk); g++; end
        if (busy) chk("wait_idle", 32'(busy), 32'd0);
        start = 1'b1; op = o; a = x; b = y;
        if (push) sbq.push_back(model(o, x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() > 0 && g < 500) begin @(negedge clk); g++; end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [31:0] x, y;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
        drain();

        // MULTU, then DIV launched in the done cycle; DIV busy span measured
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);
        cnt = 0;
        while (!done && cnt < 20) begin @(negedge clk); cnt++; end
        chk("multu_done_seen", 32'(done), 32'd1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; @(negedge clk); end
        chk("div_busy_cycles", 32'(cnt), 32'd34);
        drain();

        issue(2'b11, 32'd7, 32'd2, 1'b1);
        issue(2'b11, 32'd7, 32'd0, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Flush partway through a divide: no done, results untouched
        issue(2'b10, 32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi, last_hi);
        chk("flush_lo", lo, last_lo);
        chk("flush_dbz", 32'(dbz), 32'(last_dbz));
        repeat (40) @(negedge clk);

        // Start while busy is ignored
        issue(2'b11, 32'd12345, 32'd77, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore", 32'(busy), 32'd1);
        drain();

        // Flush and start together: nothing happens
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Randomized mix, including zero divisors and the overflow pair
        for (int i = 0; i < 40; i++) begin
            x = $urandom; y = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            issue(2'($urandom_range(0, 3)), x, y, 1'b1);
        end
        drain();

        // Reset in the middle of a divide
        issue(2'b10, 32'hDEAD_BEEF, 32'd13, 1'b0);
        repeat (8) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd4, 32'd4, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
